// File: rtl/minterm_extractor.sv
// Purpose: probes an N-input combinational function, captures its truth table, streams minterm indices.
// Latency: DONE 2*2^N cycles after start, plus one cycle per stalled valid; indices ascending.
// Backpressure: valid/ready; a selected index holds m_valid/m_index until m_ready, unselected skip.
// Optional: MINTERM_EXTRACT_MAXTERM_EN adds sel_max to stream maxterm indices instead.
module minterm_extractor #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef MINTERM_EXTRACT_MAXTERM_EN
  input  logic                sel_max,
`endif
  output logic [N-1:0]        probe,
  input  logic                f_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N-1:0]        m_index,
  output logic                busy,
  output logic                done,
  output logic [N:0]          count,
  output logic [(1<<N)-1:0]   mask
);

  localparam int M = 1 << N;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t       state;
  logic [N-1:0] idx;        // probe counter, walks 0..M-1 during SCAN, 0 otherwise
  logic [N-1:0] ptr;        // emit pointer, walks 0..M-1 during EMIT, 0 otherwise
  logic         sel_max_q;  // polarity of the run, frozen at start
  logic [M-1:0] sel;
  logic         sel_cur;
  logic         f_sel;
  logic         advance;

`ifndef MINTERM_EXTRACT_MAXTERM_EN
  assign sel_max_q = 1'b0;
`endif

  // Selection view of the truth table; mask itself always keeps true f values.
  assign sel     = sel_max_q ? ~mask : mask;
  assign sel_cur = sel[ptr];
  assign f_sel   = f_in ^ sel_max_q;
  // Unselected slots skip in one cycle; selected slots wait for the consumer.
  assign advance = ~sel_cur | m_ready;

  // Outputs are pure decodes of registers, so no input reaches them combinationally.
  assign probe   = idx;
  assign m_index = ptr;
  assign m_valid = (state == EMIT) && sel_cur;

  // Control FSM with its datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= '0;
      mask  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MINTERM_EXTRACT_MAXTERM_EN
      sel_max_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SCAN;
            idx   <= '0;
            ptr   <= '0;
            mask  <= '0;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef MINTERM_EXTRACT_MAXTERM_EN
            sel_max_q <= sel_max;
`endif
          end
        end
        SCAN: begin
          mask[idx] <= f_in;
          count     <= count + {{N{1'b0}}, f_sel};
          idx       <= idx + 1'b1;  // wraps back to 0 after the last probe
          if (&idx) begin
            state <= EMIT;
            ptr   <= '0;
          end
        end
        EMIT: begin
          if (advance) begin
            if (&ptr) begin
              state <= DONE;
              ptr   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
